// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: writeback select encodings,
// load funct3 codes and default datapath widths.
package rv_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam int REGINDEX_DEF  = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3[2] clear marks the sign-extending load variants
    function automatic logic is_signed_load(input logic [2:0] funct3);
        return ~funct3[2];
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load alignment: picks the byte/halfword lane from a memory word
// and sign- or zero-extends it to the register width.
module load_ext
    import rv_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic [DATAWIDTH-1:0] word,
    input  logic [2:0]           funct3,
    input  logic [1:0]           off,
    output logic [DATAWIDTH-1:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    assign byte_lane = word[{off, 3'b000} +: 8];
    assign half_lane = off[1] ? word[31:16] : word[15:0];
    assign sext      = is_signed_load(funct3);

    always_comb begin
        ext = word;
        case (funct3)
            F3_LB, F3_LBU: ext = {{(DATAWIDTH-8){sext & byte_lane[7]}}, byte_lane};
            F3_LH, F3_LHU: ext = {{(DATAWIDTH-16){sext & half_lane[15]}}, half_lane};
            default:       ext = word;
        endcase
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: selects the writeback value, commits it to the
// integer register file (write-first bypass) and counts retirements.
module wb_stage_regfile
    import rv_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int REGINDEX  = REGINDEX_DEF,
    parameter int CNTWIDTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 valid_in,
    input  logic [1:0]           wbsel_in,
    input  logic                 regwrite_in,
    input  logic [REGINDEX-1:0]  regdindex_in,
    input  logic [DATAWIDTH-1:0] data_alu_in,
    input  logic [DATAWIDTH-1:0] data_mem_in,
    input  logic [DATAWIDTH-1:0] pc4_in,
    input  logic [2:0]           ld_funct3_in,
    input  logic [1:0]           ld_off_in,
    input  logic [REGINDEX-1:0]  rs1_index,
    input  logic [REGINDEX-1:0]  rs2_index,
    output logic [DATAWIDTH-1:0] rs1_data,
    output logic [DATAWIDTH-1:0] rs2_data,
    output logic [DATAWIDTH-1:0] wb_data,
    output logic                 wb_we,
    output logic [CNTWIDTH-1:0]  instret
);

    localparam int NREG = 2 ** REGINDEX;

    logic [DATAWIDTH-1:0] regs [NREG];
    logic [DATAWIDTH-1:0] load_data;
    logic                 retire;

    load_ext #(
        .DATAWIDTH (DATAWIDTH)
    ) u_load_ext (
        .word   (data_mem_in),
        .funct3 (ld_funct3_in),
        .off    (ld_off_in),
        .ext    (load_data)
    );

    always_comb begin
        wb_data = '0;
        case (wbsel_in)
            WB_SEL_ALU: wb_data = data_alu_in;
            WB_SEL_MEM: wb_data = load_data;
            WB_SEL_PC4: wb_data = pc4_in;
            default:    wb_data = '0;
        endcase
    end

    // x0 and the reserved select never produce a write, so the bypass below
    // cannot leak a non-zero value onto index 0
    assign wb_we = en & valid_in & regwrite_in
                 & (wbsel_in != WB_SEL_RSVD)
                 & (|regdindex_in);

    assign retire = en & valid_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[regdindex_in] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNTWIDTH'(1);
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_index == '0) begin
            rs1_data = '0;
        end else if (wb_we && rs1_index == regdindex_in) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs[rs1_index];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_index == '0) begin
            rs2_data = '0;
        end else if (wb_we && rs2_index == regdindex_in) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs[rs2_index];
        end
    end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboard bench for wb_stage_regfile: stimulus queues expected
// values, a negedge monitor drains and compares them.
module tb_wb_stage_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic [1:0]  wbsel_in;
    logic        regwrite_in;
    logic [4:0]  regdindex_in;
    logic [31:0] data_alu_in;
    logic [31:0] data_mem_in;
    logic [31:0] pc4_in;
    logic [2:0]  ld_funct3_in;
    logic [1:0]  ld_off_in;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [63:0] instret;

    localparam int S_RS1 = 0;
    localparam int S_RS2 = 1;
    localparam int S_WBD = 2;
    localparam int S_WE  = 3;
    localparam int S_CNT = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_stage_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .valid_in     (valid_in),
        .wbsel_in     (wbsel_in),
        .regwrite_in  (regwrite_in),
        .regdindex_in (regdindex_in),
        .data_alu_in  (data_alu_in),
        .data_mem_in  (data_mem_in),
        .pc4_in       (pc4_in),
        .ld_funct3_in (ld_funct3_in),
        .ld_off_in    (ld_off_in),
        .rs1_index    (rs1_index),
        .rs2_index    (rs2_index),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .instret      (instret)
    );

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            S_RS1:   return {32'h0, rs1_data};
            S_RS2:   return {32'h0, rs2_data};
            S_WBD:   return {32'h0, wb_data};
            S_WE:    return {63'h0, wb_we};
            default: return instret;
        endcase
    endfunction

    // monitor: compare everything queued for the current cycle
    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] a;
        while (q.size() > 0) begin
            c = q.pop_front();
            a = actual(c.sel);
            checks++;
            if (a !== c.exp) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h", c.name, a, c.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int s, input logic [63:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en           = 1'b1;
        valid_in     = 1'b0;
        regwrite_in  = 1'b0;
        wbsel_in     = 2'b00;
        regdindex_in = 5'd0;
        data_alu_in  = 32'h0;
        ld_funct3_in = 3'b010;
        ld_off_in    = 2'b00;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] v);
        en           = 1'b1;
        valid_in     = 1'b1;
        regwrite_in  = 1'b1;
        wbsel_in     = 2'b00;
        regdindex_in = rd;
        data_alu_in  = v;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t lv[$];

    initial begin
        rst         = 1'b0;
        data_mem_in = 32'h0;
        pc4_in      = 32'h0000_1004;
        rs1_index   = 5'd0;
        rs2_index   = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        expect_v("reset_instret", S_CNT, 64'd0);

        for (int i = 1; i < 32; i++) begin
            step();
            rs1_index = 5'(i);
            rs2_index = 5'(32 - i);
            expect_v($sformatf("reset_rs1_x%0d", i), S_RS1, 64'd0);
            expect_v($sformatf("reset_rs2_x%0d", 32 - i), S_RS2, 64'd0);
        end

        // write with same-cycle bypass
        step();
        wr(5'd5, 32'hDEAD_BEEF);
        rs1_index = 5'd5;
        expect_v("bypass_rs1", S_RS1, 64'hDEAD_BEEF);
        expect_v("bypass_we", S_WE, 64'd1);
        expect_v("bypass_wbdata", S_WBD, 64'hDEAD_BEEF);
        step();
        idle();
        rs2_index = 5'd5;
        expect_v("stored_rs1_x5", S_RS1, 64'hDEAD_BEEF);
        expect_v("stored_rs2_x5", S_RS2, 64'hDEAD_BEEF);
        expect_v("instret_1", S_CNT, 64'd1);

        // x0 guard
        step();
        rs1_index = 5'd0;
        wr(5'd0, 32'h1234_5678);
        expect_v("x0_we", S_WE, 64'd0);
        expect_v("x0_rs1_before", S_RS1, 64'd0);
        expect_v("x0_wbdata", S_WBD, 64'h1234_5678);
        step();
        idle();
        expect_v("x0_rs1_after", S_RS1, 64'd0);
        expect_v("instret_2", S_CNT, 64'd2);

        // load extension, combinational only
        lv.push_back('{3'b000, 2'd0, 32'hFFFF_FF82});
        lv.push_back('{3'b100, 2'd3, 32'h0000_0080});
        lv.push_back('{3'b001, 2'd2, 32'hFFFF_80F1});
        lv.push_back('{3'b101, 2'd1, 32'h0000_7F82});
        lv.push_back('{3'b010, 2'd3, 32'h80F1_7F82});
        lv.push_back('{3'b011, 2'd1, 32'h80F1_7F82});
        lv.push_back('{3'b000, 2'd1, 32'h0000_007F});
        lv.push_back('{3'b100, 2'd2, 32'h0000_00F1});
        lv.push_back('{3'b001, 2'd3, 32'hFFFF_80F1});
        lv.push_back('{3'b101, 2'd2, 32'h0000_80F1});
        lv.push_back('{3'b110, 2'd2, 32'h80F1_7F82});
        data_mem_in = 32'h80F1_7F82;
        foreach (lv[k]) begin
            step();
            wbsel_in     = 2'b01;
            ld_funct3_in = lv[k].f3;
            ld_off_in    = lv[k].off;
            expect_v($sformatf("load_f3_%0d_off_%0d", lv[k].f3, lv[k].off),
                     S_WBD, {32'h0, lv[k].exp});
        end

        // committed load, then pc4 select
        step();
        wr(5'd6, 32'h0);
        wbsel_in     = 2'b01;
        ld_funct3_in = 3'b101;
        ld_off_in    = 2'd1;
        step();
        wr(5'd4, 32'h0);
        wbsel_in  = 2'b10;
        rs2_index = 5'd6;
        rs1_index = 5'd4;
        expect_v("load_commit_x6", S_RS2, 64'h0000_7F82);
        expect_v("pc4_bypass", S_RS1, 64'h0000_1004);
        expect_v("instret_3", S_CNT, 64'd3);

        // reserved select and stall suppression
        step();
        wr(5'd7, 32'h0000_AAAA);
        step();
        wr(5'd7, 32'h5555_5555);
        wbsel_in  = 2'b11;
        rs1_index = 5'd7;
        expect_v("rsvd_we", S_WE, 64'd0);
        expect_v("rsvd_wbdata", S_WBD, 64'd0);
        expect_v("rsvd_no_bypass", S_RS1, 64'h0000_AAAA);
        step();
        idle();
        expect_v("rsvd_hold_x7", S_RS1, 64'h0000_AAAA);
        expect_v("instret_rsvd", S_CNT, 64'd6);
        step();
        wr(5'd7, 32'h0000_BBBB);
        en = 1'b0;
        expect_v("stall_we", S_WE, 64'd0);
        expect_v("stall_no_bypass", S_RS1, 64'h0000_AAAA);
        step();
        idle();
        expect_v("stall_hold_x7", S_RS1, 64'h0000_AAAA);
        expect_v("instret_stall", S_CNT, 64'd6);

        // both ports on the bypass
        step();
        wr(5'd8, 32'hCAFE_F00D);
        rs1_index = 5'd8;
        rs2_index = 5'd8;
        expect_v("dual_bypass_rs1", S_RS1, 64'hCAFE_F00D);
        expect_v("dual_bypass_rs2", S_RS2, 64'hCAFE_F00D);

        // async reset mid-stream
        step();
        wr(5'd10, 32'h0000_0010);
        step();
        wr(5'd11, 32'h0000_0011);
        step();
        idle();
        rs1_index = 5'd10;
        rs2_index = 5'd11;
        expect_v("pre_reset_x10", S_RS1, 64'h0000_0010);
        expect_v("pre_reset_x11", S_RS2, 64'h0000_0011);
        expect_v("pre_reset_instret", S_CNT, 64'd9);
        step();
        wr(5'd9, 32'h7777_7777);
        rst = 1'b0;
        expect_v("async_rst_x10", S_RS1, 64'd0);
        expect_v("async_rst_x11", S_RS2, 64'd0);
        expect_v("async_rst_instret", S_CNT, 64'd0);
        step();
        rst = 1'b1;
        idle();
        rs1_index = 5'd9;
        expect_v("rst_write_dropped", S_RS1, 64'd0);
        expect_v("rst_instret_held", S_CNT, 64'd0);
        step();
        wr(5'd12, 32'h0000_0001);
        step();
        idle();
        rs1_index = 5'd12;
        expect_v("post_rst_write", S_RS1, 64'd1);
        expect_v("post_rst_instret", S_CNT, 64'd1);

        for (int t = 0; t < 5 && q.size() > 0; t++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
